// File: rtl/stereo_mult_scheduler_pkg.sv
// rtl/stereo_mult_scheduler_pkg.sv - shared widths, timeout default and FSM encoding
package stereo_mult_scheduler_pkg;

    localparam int DEF_N       = 18;
    localparam int DEF_M       = 5;
    localparam int DEF_TIMEOUT = 64;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START_S = 3'd1;
    localparam logic [2:0] ST_WAIT_S  = 3'd2;
    localparam logic [2:0] ST_START_D = 3'd3;
    localparam logic [2:0] ST_WAIT_D  = 3'd4;
    localparam logic [2:0] ST_PUBLISH = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        START_S = ST_START_S,
        WAIT_S  = ST_WAIT_S,
        START_D = ST_START_D,
        WAIT_D  = ST_WAIT_D,
        PUBLISH = ST_PUBLISH
    } state_t;

endpackage

// File: rtl/stereo_mult_scheduler.sv
// rtl/stereo_mult_scheduler.sv - shares one external multiplier between L+R and L-R gain jobs
module stereo_mult_scheduler
    import stereo_mult_scheduler_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int M       = DEF_M,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clken_48,
    input  logic [N-1:0] LEFT,
    input  logic [N-1:0] RIGHT,
    input  logic [M-2:0] Ks,
    input  logic [M-2:0] Kd,
    input  logic         clear_flags,
    output logic         mult_start,
    output logic [M-1:0] mult_A,
    output logic [N-1:0] mult_B,
    input  logic         mult_ready,
    input  logic [N-1:0] mult_R,
    output logic [N-1:0] LI_in_LpR,
    output logic [N-1:0] LI_in_LmR,
    output logic         out_valid,
    output logic         busy,
    output logic         overrun,
    output logic         timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t         state, state_nx;
    logic [CW-1:0]  wait_cnt;
    logic [N:0]     sum_w, diff_w;
    logic [N-1:0]   lmr_r, res_s;
    logic [M-1:0]   kd_r;
    logic           in_wait, rdy_ok, to_hit;
    logic           unused_lsbs;

    // 19-bit sum/difference so the halving never overflows
    assign sum_w       = {LEFT[N-1], LEFT} + {RIGHT[N-1], RIGHT};
    assign diff_w      = {LEFT[N-1], LEFT} - {RIGHT[N-1], RIGHT};
    assign unused_lsbs = sum_w[0] ^ diff_w[0];

    // wait_cnt==0 is the guard cycle: a ready level left over from the previous job is ignored
    assign in_wait = (state == WAIT_S) || (state == WAIT_D);
    assign rdy_ok  = in_wait && (wait_cnt != '0) && mult_ready;
    assign to_hit  = in_wait && !rdy_ok && (wait_cnt == CW'(TIMEOUT - 1));

    // next-state and decoded outputs
    always_comb begin
        state_nx   = state;
        mult_start = 1'b0;
        out_valid  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE:    if (clken_48) state_nx = START_S;
            START_S: begin
                mult_start = 1'b1;
                state_nx   = WAIT_S;
            end
            WAIT_S:  begin
                if (rdy_ok)      state_nx = START_D;
                else if (to_hit) state_nx = IDLE;
            end
            START_D: begin
                mult_start = 1'b1;
                state_nx   = WAIT_D;
            end
            WAIT_D:  begin
                if (rdy_ok)      state_nx = PUBLISH;
                else if (to_hit) state_nx = IDLE;
            end
            PUBLISH: begin
                out_valid = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // cycles spent in the current WAIT state, restarted on every WAIT entry
    always_ff @(posedge clock) begin
        if (reset || !in_wait) wait_cnt <= '0;
        else                   wait_cnt <= wait_cnt + CW'(1);
    end

    // sample capture, operand staging and two-result publish
    always_ff @(posedge clock) begin
        if (reset) begin
            mult_A    <= '0;
            mult_B    <= '0;
            lmr_r     <= '0;
            kd_r      <= '0;
            res_s     <= '0;
            LI_in_LpR <= '0;
            LI_in_LmR <= '0;
        end else begin
            if (state == IDLE && clken_48) begin
                mult_A <= {1'b0, Ks};
                mult_B <= sum_w[N:1];
                lmr_r  <= diff_w[N:1];
                kd_r   <= {1'b0, Kd};
            end
            if (state == WAIT_S && rdy_ok) begin
                res_s  <= mult_R;
                mult_A <= kd_r;
                mult_B <= lmr_r;
            end
            if (state == WAIT_D && rdy_ok) begin
                LI_in_LpR <= res_s;
                LI_in_LmR <= mult_R;
            end
        end
    end

    // sticky status; a set event beats a simultaneous clear
    always_ff @(posedge clock) begin
        if (reset) begin
            overrun <= 1'b0;
            timeout <= 1'b0;
        end else begin
            overrun <= (overrun & ~clear_flags) | (clken_48 & (state != IDLE));
            timeout <= (timeout & ~clear_flags) | to_hit;
        end
    end

endmodule

// File: doc/stereo_mult_scheduler.md
Name: stereo_mult_scheduler

Overview:
- Time-shares one external sequential saturating multiplier (5b signed x 18b signed -> 18b saturated) between the L+R and L-R channels.
- On each 48 kHz clock-enable it samples LEFT/RIGHT/Ks/Kd and forms the half-scaled sum and difference.
- It then runs two multiply jobs back to back: Ks*LpR first, then Kd*LmR.
- Both results are published together as held outputs, with a valid pulse, busy, overrun and timeout status.

Parameters:
- N, 18, sample/result width.
- M, 5, multiplier A-operand width (gain zero-extended from M-1 bits).
- TIMEOUT, 64, max cycles spent in a WAIT state before abort (>=4).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- clken_48  in  1  one-cycle 48 kHz sample strobe.
- LEFT  in  N  signed left sample.
- RIGHT  in  N  signed right sample.
- Ks  in  M-1  unsigned sum gain.
- Kd  in  M-1  unsigned difference gain.
- clear_flags  in  1  clears sticky flags.
- mult_start  out  1  one-cycle start to multiplier.
- mult_A  out  M  signed gain operand.
- mult_B  out  N  signed sample operand.
- mult_ready  in  1  multiplier ready/result valid (level).
- mult_R  in  N  multiplier saturated result.
- LI_in_LpR  out  N  held Ks*LpR result.
- LI_in_LmR  out  N  held Kd*LmR result.
- out_valid  out  1  one-cycle pulse: both outputs just updated.
- busy  out  1  high in any state except IDLE.
- overrun  out  1  sticky: clken_48 arrived while busy.
- timeout  out  1  sticky: multiplier never became ready.

Behaviour:
- Clock and reset: single clock domain; reset synchronous, active-high, highest priority.
- Reset values: state=IDLE; all outputs 0; internal sample registers 0. Reset mid-job aborts immediately; no out_valid follows.
- Sample arithmetic, on the IDLE+clken_48 edge: sum = sign-extended 19b LEFT+RIGHT; diff = LEFT-RIGHT; LpR_r=sum[N:1], LmR_r=diff[N:1] (arithmetic halve, truncates toward -inf). Ks_r={1'b0,Ks}, Kd_r={1'b0,Kd}.
- FSM states: IDLE, START_S, WAIT_S, START_D, WAIT_D, PUBLISH.
  - IDLE: clken_48 -> START_S.
  - START_S: mult_start=1, mult_A=Ks_r, mult_B=LpR_r; -> WAIT_S.
  - WAIT_S: first cycle is a guard (mult_ready ignored). Afterwards, the first cycle with mult_ready=1 captures mult_R into res_s -> START_D.
  - START_D: as START_S with Kd_r/LmR_r; -> WAIT_D.
  - WAIT_D: same guard rule. On ready, LI_in_LpR<=res_s and LI_in_LmR<=mult_R on the same edge -> PUBLISH.
  - PUBLISH: out_valid=1 for exactly this cycle -> IDLE.
- mult_A/mult_B are registered and stay stable from START through the end of WAIT.
- mult_start is high only in START states.
- Latency: multiplier ready L>=2 cycles after start gives out_valid 3+2L cycles after the clken_48 cycle.
- Outputs never update partially; they hold between jobs.
- Timeout: a cycle counter resets on WAIT entry. If it reaches TIMEOUT with no ready: set timeout, go to IDLE, outputs unchanged, no out_valid.
- Overrun: clken_48 in any non-IDLE state sets overrun; that sample is dropped and the job in progress continues.
- clken_48 in IDLE is accepted; a PUBLISH-cycle clken_48 is an overrun.
- clear_flags clears both sticky flags. A set event in the same cycle wins (flag stays 1).

Decomposition:
- Shared package holds:
  - FSM state encoding (3b localparams);
  - default N/M widths;
  - TIMEOUT default.
- No sub-module is required; the datapath is registers plus one adder/subtractor.
- The multiplier stays external so it can be shared or swapped.
- The bench instantiates the existing seqmultNM_sat or a fixed-latency model.

Test Plan:
- Basic job: model L=5; LEFT=1000, RIGHT=200, Ks=3, Kd=2, clken_48 at cycle T.
  - mult_start at T+1 and T+7; out_valid at T+13.
  - LI_in_LpR=1800; LI_in_LmR=800.
- Negative/halving: LEFT=-3, RIGHT=0, Ks=1, Kd=1.
  - LpR_r=-2, LmR_r=-2; outputs -2/-2.
  - LEFT=131071, RIGHT=131071, Ks=15: LpR_r=131071, result saturates to 131071.
- Overrun: second clken_48 at T+4.
  - overrun=1; only one out_valid, with the first sample's results.
  - clear_flags later -> overrun=0; clear_flags coincident with a new overrun -> stays 1.
- Timeout: TIMEOUT=8, model never asserts ready after start.
  - timeout=1 exactly 8 cycles after WAIT_S entry; busy=0 next.
  - Outputs keep prior values; no out_valid.
- Reset mid-job: reset at T+9 (in WAIT_D).
  - Next cycle all outputs 0, busy=0; no out_valid.
  - A following clken_48 completes normally.
- Guard cycle: model holds ready=1 in the cycle after start, then drops it for 3 cycles and re-raises it.
  - Capture occurs only on the re-raise; the stale result is not used.
